// File: rtl/proc_io_pkg.sv
// Shared constants and elaboration helpers for the proc_fx I/O bridge.
package proc_io_pkg;

  localparam int IOB_MAX_CH    = 16;
  localparam int IOB_MAX_DEPTH = 64;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit fdepth_ok(input int d);
    return (d >= 2) && (d <= IOB_MAX_DEPTH) && ((d & (d - 1)) == 0);
  endfunction

endpackage

// File: rtl/io_chan_fifo.sv
// Single-channel word FIFO: independent wrapping pointers plus an occupancy count.
// A push into a full FIFO is accepted only when a valid pop frees the slot in the same cycle.
module io_chan_fifo
  import proc_io_pkg::*;
#(
  parameter int NUBITS = 32,
  parameter int FDEPTH = 4,
  localparam int PW = clog2_min1(FDEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [NUBITS-1:0] din,
  output logic [NUBITS-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [NUBITS-1:0] mem [FDEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              pop_ok;
  logic              push_ok;
  logic [CW-1:0]     count_nxt;

  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok) begin
      count_nxt = count + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == CW'(FDEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage is not reset; the empty mask keeps stale words off the head.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/proc_io_bridge.sv
// Buffered bridge between a proc_fx single-word I/O port and NUIOIN/NUIOOU handshake channels.
// Define IOB_FLAGS_EN to add the sticky err_ovf/err_udf flag ports.
module proc_io_bridge
  import proc_io_pkg::*;
#(
  parameter int NUBITS = 32,
  parameter int NUIOIN = 2,
  parameter int NUIOOU = 2,
  parameter int FDEPTH = 4,
  localparam int AIW = clog2_min1(NUIOIN),
  localparam int AOW = clog2_min1(NUIOOU)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     proc_req_in,
  input  logic [AIW-1:0]           proc_addr_in,
  output logic [NUBITS-1:0]        proc_din,
  input  logic                     proc_out_en,
  input  logic [AOW-1:0]           proc_addr_out,
  input  logic [NUBITS-1:0]        proc_dout,
  input  logic [NUIOIN*NUBITS-1:0] in_data,
  input  logic [NUIOIN-1:0]        in_valid,
  output logic [NUIOIN-1:0]        in_ready,
  output logic [NUIOOU*NUBITS-1:0] out_data,
  output logic [NUIOOU-1:0]        out_valid,
  input  logic [NUIOOU-1:0]        out_ready
`ifdef IOB_FLAGS_EN
  ,
  output logic [NUIOOU-1:0]        err_ovf,
  output logic [NUIOIN-1:0]        err_udf
`endif
);

  localparam int CW = clog2_min1(FDEPTH) + 1;

  if (!fdepth_ok(FDEPTH) || NUIOIN < 1 || NUIOIN > IOB_MAX_CH ||
      NUIOOU < 1 || NUIOOU > IOB_MAX_CH) begin : g_bad_cfg
    $error("proc_io_bridge: illegal channel count or FIFO depth");
  end

  logic [NUIOIN-1:0] rd_sel;
  logic [NUIOIN-1:0] in_pop;
  logic [NUIOIN-1:0] in_empty;
  logic [NUBITS-1:0] rd_word [NUIOIN];
  logic [NUIOOU-1:0] wr_sel;
  logic [NUIOOU-1:0] out_pop;
`ifdef IOB_FLAGS_EN
  logic [NUIOOU-1:0] ovf_evt;
`endif

  // Input side: external push, processor pop with a per-channel hold register.
  for (genvar k = 0; k < NUIOIN; k++) begin : g_in
    logic [CW-1:0]     cnt;
    logic [NUBITS-1:0] head;
    logic [NUBITS-1:0] hold;
    logic              unused_full;

    assign rd_sel[k] = (proc_addr_in == AIW'(k));
    assign in_pop[k] = proc_req_in & rd_sel[k];

    io_chan_fifo #(.NUBITS(NUBITS), .FDEPTH(FDEPTH)) u_fifo (
      .clk,
      .rst,
      .push  (in_valid[k] & in_ready[k]),
      .pop   (in_pop[k]),
      .din   (in_data[k*NUBITS +: NUBITS]),
      .head  (head),
      .full  (unused_full),
      .empty (in_empty[k]),
      .count (cnt)
    );

    assign in_ready[k] = (cnt < CW'(FDEPTH));

    always_ff @(posedge clk) begin
      if (rst) begin
        hold <= '0;
      end else if (in_pop[k] && !in_empty[k]) begin
        hold <= head;
      end
    end

    assign rd_word[k] = in_empty[k] ? hold : head;
  end

  // Out-of-range addresses select no channel and read back as zero.
  always_comb begin
    proc_din = '0;
    for (int k = 0; k < NUIOIN; k++) begin
      if (rd_sel[k]) proc_din = rd_word[k];
    end
  end

  // Output side: processor push, external pop.
  for (genvar j = 0; j < NUIOOU; j++) begin : g_out
    logic [CW-1:0] cnt;
    logic          full;
    logic          unused_empty;

    assign wr_sel[j]  = proc_out_en & (proc_addr_out == AOW'(j));
    assign out_pop[j] = out_valid[j] & out_ready[j];

    io_chan_fifo #(.NUBITS(NUBITS), .FDEPTH(FDEPTH)) u_fifo (
      .clk,
      .rst,
      .push  (wr_sel[j]),
      .pop   (out_pop[j]),
      .din   (proc_dout),
      .head  (out_data[j*NUBITS +: NUBITS]),
      .full  (full),
      .empty (unused_empty),
      .count (cnt)
    );

    assign out_valid[j] = (cnt != '0);

`ifdef IOB_FLAGS_EN
    assign ovf_evt[j] = wr_sel[j] & full & ~out_pop[j];
`else
    logic unused_full;
    assign unused_full = full;
`endif
  end

`ifdef IOB_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovf <= '0;
      err_udf <= '0;
    end else begin
      err_ovf <= err_ovf | ovf_evt;
      err_udf <= err_udf | (in_pop & in_empty);
    end
  end
`endif

endmodule

// File: tb/tb_proc_io_bridge.sv
// Directed plus randomized bench for proc_io_bridge against a queue-based reference model.
module tb_proc_io_bridge;

  localparam int NB  = 32;
  localparam int NIN = 3;
  localparam int NOU = 3;
  localparam int FD  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              proc_req_in;
  logic [1:0]        proc_addr_in;
  logic [NB-1:0]     proc_din;
  logic              proc_out_en;
  logic [1:0]        proc_addr_out;
  logic [NB-1:0]     proc_dout;
  logic [NIN*NB-1:0] in_data;
  logic [NIN-1:0]    in_valid;
  logic [NIN-1:0]    in_ready;
  logic [NOU*NB-1:0] out_data;
  logic [NOU-1:0]    out_valid;
  logic [NOU-1:0]    out_ready;
`ifdef IOB_FLAGS_EN
  logic [NOU-1:0]    err_ovf;
  logic [NIN-1:0]    err_udf;
`endif

  proc_io_bridge #(.NUBITS(NB), .NUIOIN(NIN), .NUIOOU(NOU), .FDEPTH(FD)) dut (
    .clk           (clk),
    .rst           (rst),
    .proc_req_in   (proc_req_in),
    .proc_addr_in  (proc_addr_in),
    .proc_din      (proc_din),
    .proc_out_en   (proc_out_en),
    .proc_addr_out (proc_addr_out),
    .proc_dout     (proc_dout),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready)
`ifdef IOB_FLAGS_EN
    ,
    .err_ovf       (err_ovf),
    .err_udf       (err_udf)
`endif
  );

  always #5 clk = ~clk;

  logic [NB-1:0]  mi [NIN][$];
  logic [NB-1:0]  mo [NOU][$];
  logic [NB-1:0]  mhold [NIN];
  logic [NIN-1:0] mudf;
  logic [NOU-1:0] movf;
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NIN; k++) begin
      mi[k].delete();
      mhold[k] = '0;
    end
    for (int j = 0; j < NOU; j++) mo[j].delete();
    mudf = '0;
    movf = '0;
  endtask

  task automatic check_outputs();
    logic [NIN-1:0] er;
    logic [NOU-1:0] ev;
    logic [NB-1:0]  ed;
    for (int k = 0; k < NIN; k++) er[k] = (mi[k].size() < FD);
    for (int j = 0; j < NOU; j++) ev[j] = (mo[j].size() != 0);
    check("in_ready", 32'(in_ready), 32'(er));
    check("out_valid", 32'(out_valid), 32'(ev));
    for (int j = 0; j < NOU; j++) begin
      ed = (mo[j].size() != 0) ? mo[j][0] : '0;
      check($sformatf("out_data%0d", j), out_data[j*NB +: NB], ed);
    end
    if (proc_addr_in < NIN) ed = (mi[proc_addr_in].size() != 0) ? mi[proc_addr_in][0] : mhold[proc_addr_in];
    else ed = '0;
    check("proc_din", proc_din, ed);
`ifdef IOB_FLAGS_EN
    check("err_udf", 32'(err_udf), 32'(mudf));
    check("err_ovf", 32'(err_ovf), 32'(movf));
`endif
  endtask

  // Applies one clock edge of the specified behaviour to the queues.
  task automatic model_update();
    int  n;
    bit  popped;
    if (rst) begin
      model_clear();
      return;
    end
    for (int k = 0; k < NIN; k++) begin
      n = mi[k].size();
      if (proc_req_in && proc_addr_in == k) begin
        if (n > 0) mhold[k] = mi[k].pop_front();
        else mudf[k] = 1'b1;
      end
      if (in_valid[k] && n < FD) mi[k].push_back(in_data[k*NB +: NB]);
    end
    for (int j = 0; j < NOU; j++) begin
      n = mo[j].size();
      popped = out_ready[j] && n > 0;
      if (popped) void'(mo[j].pop_front());
      if (proc_out_en && proc_addr_out == j) begin
        if (n < FD || popped) mo[j].push_back(proc_dout);
        else movf[j] = 1'b1;
      end
    end
  endtask

  task automatic step();
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    proc_req_in   = 1'b0;
    proc_addr_in  = '0;
    proc_out_en   = 1'b0;
    proc_addr_out = '0;
    proc_dout     = '0;
    in_data       = '0;
    in_valid      = '0;
    out_ready     = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    model_clear();
    idle();
    rst = 1'b1;
    @(negedge clk);
    #1 step();
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'h7);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_proc_din", proc_din, 32'h0);
    step();

    // Two pushes on input channel 1, then three reads.
    in_valid = 3'b010;
    in_data[1*NB +: NB] = 32'h11;
    #1 step();
    in_data[1*NB +: NB] = 32'h22;
    #1 step();
    check("in1_ready", 32'(in_ready[1]), 32'h1);
    idle();
    proc_req_in = 1'b1;
    proc_addr_in = 2'd1;
    #1 check("rd1_first", proc_din, 32'h11);
    step();
    #1 check("rd1_second", proc_din, 32'h22);
    step();
    #1 check("rd1_hold", proc_din, 32'h22);
    step();
`ifdef IOB_FLAGS_EN
    check("udf1_set", 32'(err_udf[1]), 32'h1);
`endif
    idle();

    // Overfill output channel 0 with no consumer.
    proc_out_en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      proc_dout = 32'(i);
      #1 step();
    end
    idle();
    #1 check("out0_valid_full", 32'(out_valid[0]), 32'h1);
`ifdef IOB_FLAGS_EN
    check("ovf0_set", 32'(err_ovf[0]), 32'h1);
`endif
    out_ready[0] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("out0_pop%0d", i), out_data[0 +: NB], 32'(i));
      step();
      #1;
    end
    out_ready = '0;
    check("out0_drained", 32'(out_valid[0]), 32'h0);
    step();

    // Full output channel 1 with simultaneous pop and push.
    proc_out_en = 1'b1;
    proc_addr_out = 2'd1;
    for (int i = 0; i < 4; i++) begin
      proc_dout = 32'h10 + 32'(i);
      #1 step();
    end
    proc_dout = 32'h99;
    out_ready[1] = 1'b1;
    #1 check("out1_head_full", out_data[NB +: NB], 32'h10);
    step();
    proc_out_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("out1_drain%0d", i), out_data[NB +: NB], (i == 3) ? 32'h99 : 32'h11 + 32'(i));
      step();
    end
    idle();

    // Empty input channel 0 pushed and read in the same cycle.
    in_valid = 3'b001;
    in_data[0 +: NB] = 32'hAB;
    proc_req_in = 1'b1;
    proc_addr_in = 2'd0;
    #1 check("rd0_empty_hold", proc_din, 32'h0);
    step();
`ifdef IOB_FLAGS_EN
    check("udf0_set", 32'(err_udf[0]), 32'h1);
`endif
    in_valid = '0;
    #1 check("rd0_after_push", proc_din, 32'hAB);
    step();

    // Out-of-range read and write.
    proc_addr_in = 2'd3;
    proc_out_en = 1'b1;
    proc_addr_out = 2'd3;
    proc_dout = 32'hDEAD;
    #1 check("rd_oob", proc_din, 32'h0);
    step();
    idle();

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      proc_req_in   = 1'($urandom);
      proc_addr_in  = 2'($urandom_range(0, 3));
      proc_out_en   = 1'($urandom);
      proc_addr_out = 2'($urandom_range(0, 3));
      proc_dout     = $urandom;
      for (int k = 0; k < NIN; k++) in_data[k*NB +: NB] = $urandom;
      in_valid  = 3'($urandom);
      out_ready = 3'($urandom);
      #1 step();
    end
    idle();

    // Reset with three words buffered in every FIFO.
    rst = 1'b1;
    #1 step();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_valid = (i < 3) ? 3'b111 : 3'b000;
      for (int k = 0; k < NIN; k++) in_data[k*NB +: NB] = 32'h100 * 32'(k) + 32'(i);
      proc_out_en = 1'b1;
      proc_addr_out = 2'(i % 3);
      proc_dout = 32'h500 + 32'(i);
      #1 step();
    end
    idle();
    proc_req_in = 1'b1;
    proc_addr_in = 2'd2;
    rst = 1'b1;
    #1 step();
    rst = 1'b0;
    proc_req_in = 1'b0;
    #1;
    check("rst2_out_valid", 32'(out_valid), 32'h0);
    check("rst2_in_ready", 32'(in_ready), 32'h7);
    check("rst2_proc_din", proc_din, 32'h0);
`ifdef IOB_FLAGS_EN
    check("rst2_flags", 32'({err_ovf, err_udf}), 32'h0);
`endif
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/proc_io_bridge.md
Name: proc_io_bridge

Overview:
- Parametrised I/O bridge between one proc_fx core's single-word I/O port and NUIOIN input / NUIOOU output channels.
- Successor to the fixed 2-in/2-out address-decoder wrapper. Adds per-channel FIFO buffering, valid/ready handshakes on the external side, and sticky overflow/underflow flags.
- Sits between the processor instance and the top-level system pins.

Parameters:
- NUBITS, 32, data word width.
- NUIOIN, 2, input channel count (1..16).
- NUIOOU, 2, output channel count (1..16).
- FDEPTH, 4, words per channel FIFO; power of two, 2..64.
- Derived AIW = (NUIOIN>1) ? clog2(NUIOIN) : 1.
- Derived AOW = (NUIOOU>1) ? clog2(NUIOOU) : 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- proc_req_in  in  1  processor read strobe for one cycle.
- proc_addr_in  in  AIW  input channel selected for the read.
- proc_din  out  NUBITS  word returned to the processor, combinational.
- proc_out_en  in  1  processor write strobe for one cycle.
- proc_addr_out  in  AOW  output channel selected for the write.
- proc_dout  in  NUBITS  word written by the processor.
- in_data  in  NUIOIN*NUBITS  input channel words; channel k occupies [k*NUBITS +: NUBITS].
- in_valid  in  NUIOIN  per-channel push request.
- in_ready  out  NUIOIN  per-channel not-full.
- out_data  out  NUIOOU*NUBITS  output FIFO head words.
- out_valid  out  NUIOOU  per-channel not-empty.
- out_ready  in  NUIOOU  per-channel pop request.
- err_ovf  out  NUIOOU  sticky output-overflow flags; present only with IOB_FLAGS_EN.
- err_udf  out  NUIOIN  sticky input-underflow flags; present only with IOB_FLAGS_EN.

Behaviour:
- Reset: all FIFOs empty. in_ready all 1, out_valid all 0, out_data all 0, proc_din 0, hold registers 0, flags 0. Reset mid-operation discards buffered data, with no partial state left.
- Each channel has a FIFO with independent write and read pointers (FDEPTH entries) and a count register of clog2(FDEPTH)+1 bits. Pointers wrap modulo FDEPTH.
- External push: in_valid[k] & in_ready[k] writes in_data slice k at the rising edge. Word is visible at the head the next cycle, so latency is 1 cycle.
- External pop: out_valid[j] & out_ready[j] pops at the rising edge. out_data[j] always shows the head word; 0 when empty.
- Processor read:
  - proc_din = head of input FIFO proc_addr_in when that FIFO is non-empty; otherwise the channel's hold register (last word read).
  - proc_req_in pops that FIFO and loads its hold register with the popped word.
  - Read of an empty FIFO: no pop, hold register unchanged, err_udf[ch] set.
- Processor write: proc_out_en pushes proc_dout into output FIFO proc_addr_out. If that FIFO is full and not popped in the same cycle, the word is dropped and err_ovf[ch] is set.
- Out-of-range address (>= channel count): read returns 0 with no state change; write is ignored. No flag is set in either case.
- Simultaneous push and pop on the same FIFO:
  - Both execute; count unchanged.
  - When full: the push is accepted because the pop frees the slot. in_ready still reads 0 at full; the processor-side push uses the full-with-pop rule.
  - When empty: the pop is invalid (underflow rule applies) and the push completes.
- in_ready[k] = count < FDEPTH and out_valid[j] = count != 0, both driven straight from registers.
- There is no back-pressure on the processor; loss is reported only via the flags.

Optional Feature:
- IOB_FLAGS_EN defined: err_ovf and err_udf ports exist. Flags are sticky until rst.
- IOB_FLAGS_EN undefined: the flag ports and registers are removed. Data-path behaviour is identical, including drop-on-overflow and hold-on-underflow.

Decomposition:
- Package proc_io_pkg holds:
  - a clog2-with-minimum-1 width function;
  - the FDEPTH legality check;
  - constants IOB_MAX_CH=16 and IOB_MAX_DEPTH=64.
- Sub-module io_chan_fifo (NUBITS, FDEPTH): push/pop/full/empty/count/head.
  - Instantiated NUIOIN + NUIOOU times via generate.
  - The bridge adds address decode, hold registers, flags and the read mux.

Test Plan:
- Reset then push 0x11, 0x22 on in ch1 (in_valid pulses) -> in_ready[1] stays 1. Reads on addr 1 return 0x11, then 0x22. A third read returns 0x22 with err_udf[1]=1.
- FDEPTH=4: processor writes 5 words (1..5) to out ch0 with out_ready=0 -> out_valid[0]=1 and word 5 is dropped. err_ovf[0]=1. Popping yields 1,2,3,4, then out_valid=0.
- Full out ch1 with out_ready[1]=1 and proc_out_en in the same cycle -> count stays 4 and the new word is retained at the tail.
- Empty in ch0 with in_valid[0] and proc_req_in in the same cycle (data 0xAB) -> proc_din = hold (0) and err_udf[0]=1. Next-cycle read returns 0xAB.
- rst asserted with 3 words buffered in each FIFO -> next cycle all out_valid=0, in_ready all 1, flags 0, proc_din=0.
- NUIOIN=3 with a read at addr 3 -> proc_din=0, no pop, no flag; same result with IOB_FLAGS_EN off.
